// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Registered RV32I sequencer for the multicycle core. Each instruction is
//   walked through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Memory accesses
//   use a ready handshake with an optional wait timeout. Unknown opcodes park
//   the FSM in TRAP until reset.
//
//   Build option: define MULDIV_EN to route R-type funct7=0000001 to an
//   iterative mul/div unit (MULDIV state). Without it, only MUL (funct3=000)
//   is accepted and executes as a single-cycle ALU op.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   OpCode/funct3/funct7    instruction fields from the IR
//   br_taken                branch unit result
//   mem_ready               memory completed the current request
//   muldiv_done             iterative mul/div result valid
//   PCWr, IRWr              PC / IR write enables
//   InstrRd, DMRd, DMWr     fetch / data read / data write requests
//   DMCtrl                  data access size/sign (funct3)
//   BrOp, ALUOp             branch unit / ALU operation
//   ALUASrc, ALUBSrc        ALU operand selects (PC / immediate)
//   ImmSrc                  immediate format
//   RUWr, RUDataWrSrc       register write enable / write-back source
//   muldiv_start, MulDivOp  mul/div start pulse / operation
//   bus_fault               one-cycle pulse on wait timeout
//   illegal_instr           high while in TRAP
//   state_o                 current FSM state
module multicycle_control_unit #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OpCode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_taken,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       PCWr,
  output logic       IRWr,
  output logic       InstrRd,
  output logic       DMRd,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic [4:0] BrOp,
  output logic [3:0] ALUOp,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [2:0] ImmSrc,
  output logic       RUWr,
  output logic [1:0] RUDataWrSrc,
  output logic       muldiv_start,
  output logic [2:0] MulDivOp,
  output logic       bus_fault,
  output logic       illegal_instr,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_MULDIV = 3'b101,
    S_TRAP   = 3'b110
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_wait;
  logic             w_waiting, w_timeout, w_legal, w_mext;

  assign w_mext = (OpCode == OP_R) && (funct7 == 7'b0000001);

  always_comb begin
    w_legal = 1'b0;
    case (OpCode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
      default:                           w_legal = 1'b0;
    endcase
`ifndef MULDIV_EN
    // Only single-cycle MUL is available without the iterative unit.
    if (w_mext && (funct3 != 3'b000)) w_legal = 1'b0;
`endif
  end

  // Timeout fires on the WAIT_TIMEOUT-th consecutive not-ready cycle.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = (WAIT_TIMEOUT != 0) && w_waiting &&
                     (r_wait == CNT_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      // A timeout in FETCH re-enters FETCH, so clear explicitly as well.
      if ((w_next != r_state) || w_timeout) r_wait <= '0;
      else if (w_waiting && (r_wait != '1)) r_wait <= r_wait + 1'b1;
    end
  end

`ifdef MULDIV_EN
  logic r_md_started;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_md_started <= 1'b0;
    else        r_md_started <= (r_state == S_MULDIV) && (w_next == S_MULDIV);
  end
`else
  logic w_unused_md;
  assign w_unused_md = muldiv_done;
`endif

  always_comb begin
    w_next        = r_state;
    PCWr          = 1'b0;
    IRWr          = 1'b0;
    InstrRd       = 1'b0;
    DMRd          = 1'b0;
    DMWr          = 1'b0;
    DMCtrl        = '0;
    BrOp          = '0;
    ALUOp         = '0;
    ALUASrc       = 1'b0;
    ALUBSrc       = 1'b0;
    ImmSrc        = '0;
    RUWr          = 1'b0;
    RUDataWrSrc   = '0;
    muldiv_start  = 1'b0;
    MulDivOp      = '0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        InstrRd = !w_timeout;
        if (mem_ready) begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_legal) w_next = S_TRAP;
`ifdef MULDIV_EN
        else if (w_mext) w_next = S_MULDIV;
`endif
        else w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WB;
        case (OpCode)
          OP_R: ALUOp = w_mext ? 4'b1001 : {funct7[5], funct3};
          OP_I: begin
            ALUOp   = (funct3 == 3'b101) ? {funct7[5], 3'b101} : {1'b0, funct3};
            ALUBSrc = 1'b1;
          end
          OP_LOAD: begin
            ALUBSrc = 1'b1;
            w_next  = S_MEM;
          end
          OP_STORE: begin
            ALUBSrc = 1'b1;
            ImmSrc  = 3'b001;
            w_next  = S_MEM;
          end
          OP_BR: begin
            ALUASrc = 1'b1;
            ALUBSrc = 1'b1;
            ImmSrc  = 3'b101;
            BrOp    = {2'b01, funct3};
            PCWr    = br_taken;
            w_next  = S_FETCH;
          end
          OP_JAL: begin
            ALUASrc = 1'b1;
            ALUBSrc = 1'b1;
            ImmSrc  = 3'b110;
            BrOp    = 5'b10000;
            PCWr    = 1'b1;
          end
          OP_JALR: begin
            ALUBSrc = 1'b1;
            BrOp    = 5'b10000;
            PCWr    = 1'b1;
          end
          OP_LUI: begin
            ALUBSrc = 1'b1;
            ImmSrc  = 3'b010;
          end
          OP_AUIPC: begin
            ALUASrc = 1'b1;
            ALUBSrc = 1'b1;
            ImmSrc  = 3'b010;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!w_timeout) begin
          DMRd   = (OpCode == OP_LOAD);
          DMWr   = (OpCode == OP_STORE);
          DMCtrl = funct3;
        end
        if (mem_ready)      w_next = (OpCode == OP_LOAD) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_WB: begin
        RUWr = 1'b1;
        if (OpCode == OP_LOAD)                           RUDataWrSrc = 2'b01;
        else if ((OpCode == OP_JAL) || (OpCode == OP_JALR)) RUDataWrSrc = 2'b10;
        w_next = S_FETCH;
      end
`ifdef MULDIV_EN
      S_MULDIV: begin
        muldiv_start = !r_md_started;
        MulDivOp     = funct3;
        if (muldiv_done) w_next = S_WB;
      end
`endif
      S_TRAP: illegal_instr = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  assign bus_fault = w_timeout;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] OpCode, funct7;
  logic [2:0] funct3;
  logic       br_taken, mem_ready, muldiv_done;
  logic       PCWr, IRWr, InstrRd, DMRd, DMWr;
  logic [2:0] DMCtrl;
  logic [4:0] BrOp;
  logic [3:0] ALUOp;
  logic       ALUASrc, ALUBSrc;
  logic [2:0] ImmSrc;
  logic       RUWr;
  logic [1:0] RUDataWrSrc;
  logic       muldiv_start;
  logic [2:0] MulDivOp;
  logic       bus_fault, illegal_instr;
  logic [2:0] state_o;

  multicycle_control_unit #(.WAIT_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct3(funct3), .funct7(funct7),
    .br_taken(br_taken), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .PCWr(PCWr), .IRWr(IRWr), .InstrRd(InstrRd), .DMRd(DMRd), .DMWr(DMWr),
    .DMCtrl(DMCtrl), .BrOp(BrOp), .ALUOp(ALUOp), .ALUASrc(ALUASrc),
    .ALUBSrc(ALUBSrc), .ImmSrc(ImmSrc), .RUWr(RUWr), .RUDataWrSrc(RUDataWrSrc),
    .muldiv_start(muldiv_start), .MulDivOp(MulDivOp), .bus_fault(bus_fault),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected per-cycle observation: state plus every output.
  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, instrrd, dmrd, dmwr;
    logic [2:0] dmctrl;
    logic [4:0] brop;
    logic [3:0] aluop;
    logic       asrc, bsrc;
    logic [2:0] imm;
    logic       ruwr;
    logic [1:0] wbsrc;
    logic       mds;
    logic [2:0] mdop;
    logic       bf, ill;
  } exp_t;

  typedef struct {
    exp_t e;
    logic mr;
    logic mdd;
  } step_t;

  step_t       q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [6:0]  cur_op, cur_f7;
  logic [2:0]  cur_f3;
  logic        cur_bt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t obs();
    exp_t o;
    o = {state_o, PCWr, IRWr, InstrRd, DMRd, DMWr, DMCtrl, BrOp, ALUOp, ALUASrc,
         ALUBSrc, ImmSrc, RUWr, RUDataWrSrc, muldiv_start, MulDivOp, bus_fault,
         illegal_instr};
    return o;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push(input exp_t e, input logic mr, input logic mdd);
    step_t s;
    s.e = e; s.mr = mr; s.mdd = mdd;
    q.push_back(s);
  endtask

  // A memory phase: 'stall' not-ready cycles then the ready cycle, or a full
  // timeout where the last waited cycle shows only bus_fault.
  task automatic add_wait(input exp_t held, input exp_t rdy, input bit to, input int unsigned stall);
    exp_t f;
    if (to) begin
      for (int unsigned i = 0; i < TO - 1; i++) push(held, 1'b0, 1'($urandom));
      f = blank(held.st);
      f.bf = 1'b1;
      push(f, 1'b0, 1'($urandom));
    end else begin
      for (int unsigned i = 0; i < stall; i++) push(held, 1'b0, 1'($urandom));
      push(rdy, 1'b1, 1'($urandom));
    end
  endtask

  task automatic push_trap();
    exp_t t = blank(3'd6);
    t.ill = 1'b1;
    for (int i = 0; i < 3; i++) push(t, 1'($urandom), 1'($urandom));
  endtask

  // Classes: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI,
  // 8 AUIPC, 9 M-extension, 10 random illegal opcode, 11 opcode 1111111.
  // Stall args: -1 random, -2 forced timeout, otherwise the stall count.
  task automatic gen(input int cls_i, input int f3_i, input int f7_i, input int fst_i,
                     input int mst_i, input int bt_i, input int mdn_i, output bit trapped);
    int          cls;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    bit          to;
    int unsigned st;
    exp_t        e, r, w;
    trapped = 1'b0;
    q.delete();
    cls = (cls_i >= 0) ? cls_i : int'($urandom_range(0, 10));
    f3  = (f3_i >= 0) ? 3'(f3_i) : 3'($urandom);
    f7  = (f7_i >= 0) ? 7'(f7_i) : 7'($urandom);
    if (f7_i < 0 && (cls == 0 || cls == 1)) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    if (cls == 9) f7 = 7'h01;
    case (cls)
      0, 9: op = 7'b0110011;
      1:    op = 7'b0010011;
      2:    op = 7'b0000011;
      3:    op = 7'b0100011;
      4:    op = 7'b1100011;
      5:    op = 7'b1101111;
      6:    op = 7'b1100111;
      7:    op = 7'b0110111;
      8:    op = 7'b0010111;
      11:   op = 7'b1111111;
      default: begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end
    endcase
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    cur_bt = (bt_i >= 0) ? 1'(bt_i) : 1'($urandom);

    e = blank(3'd0); e.instrrd = 1'b1;
    r = e; r.pcwr = 1'b1; r.irwr = 1'b1;
    to = (fst_i == -2) || (fst_i == -1 && $urandom_range(0, 11) == 0);
    st = (fst_i >= 0) ? fst_i : $urandom_range(0, 3);
    add_wait(e, r, to, st);
    if (to) return;

    push(blank(3'd1), 1'($urandom), 1'($urandom));

    if (cls >= 10) begin
      push_trap(); trapped = 1'b1; return;
    end
    w = blank(3'd4); w.ruwr = 1'b1;
    if (cls == 9) begin
`ifdef MULDIV_EN
      int unsigned n;
      exp_t m;
      n = (mdn_i >= 0) ? mdn_i : $urandom_range(0, 6);
      m = blank(3'd5); m.mdop = f3;
      e = m; e.mds = 1'b1;
      push(e, 1'($urandom), n == 0);
      for (int unsigned k = 1; k <= n; k++) push(m, 1'($urandom), k == n);
      push(w, 1'($urandom), 1'($urandom));
      return;
`else
      if (f3 != 3'b000) begin
        push_trap(); trapped = 1'b1; return;
      end
`endif
    end

    e = blank(3'd2);
    case (cls)
      0: e.aluop = {f7[5], f3};
      9: e.aluop = 4'b1001;
      1: begin e.aluop = (f3 == 3'd5) ? {f7[5], 3'b101} : {1'b0, f3}; e.bsrc = 1'b1; end
      2: e.bsrc = 1'b1;
      3: begin e.bsrc = 1'b1; e.imm = 3'b001; end
      4: begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b101; e.brop = {2'b01, f3}; e.pcwr = cur_bt; end
      5: begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b110; e.brop = 5'b10000; e.pcwr = 1'b1; end
      6: begin e.bsrc = 1'b1; e.brop = 5'b10000; e.pcwr = 1'b1; end
      7: begin e.bsrc = 1'b1; e.imm = 3'b010; end
      default: begin e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'b010; end
    endcase
    push(e, 1'($urandom), 1'($urandom));
    if (cls == 4) return;

    if (cls == 2 || cls == 3) begin
      e = blank(3'd3);
      if (cls == 2) e.dmrd = 1'b1; else e.dmwr = 1'b1;
      e.dmctrl = f3;
      to = (mst_i == -2) || (mst_i == -1 && $urandom_range(0, 11) == 0);
      st = (mst_i >= 0) ? mst_i : $urandom_range(0, 4);
      add_wait(e, e, to, st);
      if (to || cls == 3) return;
      w.wbsrc = 2'b01;
    end
    if (cls == 5 || cls == 6) w.wbsrc = 2'b10;
    push(w, 1'($urandom), 1'($urandom));
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    exp_t f = blank(3'd0);
    f.instrrd = 1'b1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset", 64'(obs()), 64'(f));
    @(posedge clk); #1;
    check("reset_hold", 64'(obs()), 64'(f));
    rst_n = 1'b1;
  endtask

  task automatic play(input string name, input bit trapped, input bit cut);
    int unsigned n = q.size();
    if (cut && n > 1) n = $urandom_range(1, n - 1);
    OpCode = cur_op; funct3 = cur_f3; funct7 = cur_f7; br_taken = cur_bt;
    for (int unsigned i = 0; i < n; i++) begin
      mem_ready   = q[i].mr;
      muldiv_done = q[i].mdd;
      #3;
      check($sformatf("%s[%0d]", name, i), 64'(obs()), 64'(q[i].e));
      @(posedge clk); #1;
    end
    if (trapped || cut) do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    rst_n = 1'b0; OpCode = '0; funct3 = '0; funct7 = '0;
    br_taken = 1'b0; mem_ready = 1'b0; muldiv_done = 1'b0;
    @(posedge clk); #1;
    do_reset();

    gen(0, 0, 0, 0, 0, 0, -1, t);     play("add", t, 0);
    gen(1, 5, 32, 0, 0, 0, -1, t);    play("srai", t, 0);
    gen(2, 2, 0, 0, 3, 0, -1, t);     play("lw_stall", t, 0);
    gen(3, 2, 0, 1, 0, 0, -1, t);     play("sw", t, 0);
    gen(4, 0, 0, 0, 0, 1, -1, t);     play("beq_taken", t, 0);
    gen(0, 0, 0, -2, 0, 0, -1, t);    play("fetch_timeout", t, 0);
    gen(3, 1, 0, 0, -2, 0, -1, t);    play("mem_timeout", t, 0);
    gen(11, 0, 0, 0, 0, 0, -1, t);    play("trap7f", t, 0);
    gen(9, 0, -1, 0, 0, 0, 3, t);     play("mul", t, 0);
`ifdef MULDIV_EN
    gen(9, 4, -1, 0, 0, 0, 31, t);    play("div", t, 0);
`else
    gen(9, 4, -1, 0, 0, 0, -1, t);    play("div_trap", t, 0);
`endif
    for (int k = 0; k < 200; k++) begin
      gen(-1, -1, -1, -1, -1, -1, -1, t);
      play($sformatf("rnd%0d", k), t, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
